// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register plus a small circular buffer of
// {pc, word} pairs feeding decode. Redirects flush the buffer and reload the PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [31:0]      pc;
    logic [31:0]      buf_pc   [BUF_DEPTH];
    logic [31:0]      buf_word [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       count;

    logic full;
    logic deq;
    logic enq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake decode; a dequeue frees a slot for a same-edge enqueue when full.
    always_comb begin
        full = (count == 2'(BUF_DEPTH));
        deq  = (count != 2'd0) && inst_ready;
        enq  = !redirect_valid && (!full || deq);
    end

    // Outputs come straight from state, so nothing depends on inst_ready.
    always_comb begin
        iaddr      = pc;
        inst_valid = (count != 2'd0);
        inst       = buf_word[rd_ptr];
        inst_pc    = buf_pc[rd_ptr];
    end

    // PC, buffer storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 2'd0;
            // Clearing storage makes inst/inst_pc read zero during reset.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc[i]   <= 32'd0;
                buf_word[i] <= 32'd0;
            end
        end else if (redirect_valid) begin
            // Flush; any same-edge dequeue was already taken by decode.
            pc     <= {redirect_pc[31:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 2'd0;
        end else begin
            if (enq) begin
                buf_pc[wr_ptr]   <= pc;
                buf_word[wr_ptr] <= idata;
                wr_ptr           <= ptr_inc(wr_ptr);
                pc               <= pc + 32'd4;
            end
            if (deq) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (enq && !deq) begin
                count <= count + 2'd1;
            end else if (!enq && deq) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, async reset sequences and a
// random phase, all checked against a queue-based reference of the fetch stream.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int total = 0;
    int bad   = 0;

    // Reference state: next fetch PC and PCs currently buffered, head first.
    logic [31:0] m_pc;
    logic [31:0] q[$];

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_iaddr;
    } vec_t;

    vec_t vecs[22];

    fetch_unit #(
        .RESET_PC (RST_PC),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .iaddr         (iaddr),
        .idata         (idata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    always #5 clk = ~clk;

    // Memory word is a fixed scramble of the address so inst and inst_pc differ.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign idata = memf(iaddr);

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs with the reference; called away from the rising edge.
    task automatic check_model();
        check32("sb_valid", {31'd0, inst_valid}, {31'd0, q.size() > 0});
        check32("sb_iaddr", iaddr, m_pc);
        if (q.size() > 0) begin
            check32("sb_inst_pc", inst_pc, q[0]);
            check32("sb_inst", inst, memf(q[0]));
        end
    endtask

    // Drive one cycle of inputs, advance the reference at the edge, land on negedge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        @(posedge clk);
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (rv) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else if (q.size() < 2) begin
            q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        @(negedge clk);
        check_model();
    endtask

    // Pull reset low between edges and check its effect before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check32({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        check32({tag, "_iaddr"}, iaddr, RST_PC);
        check32({tag, "_inst"}, inst, 32'd0);
        check32({tag, "_inst_pc"}, inst_pc, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check32({tag, "_hold_valid"}, {31'd0, inst_valid}, 32'd0);
        rst = 1'b1;
        q.delete();
        m_pc = RST_PC;
    endtask

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        inst_ready     = 1'b0;
        m_pc           = RST_PC;

        //          rv    rpc            rdy   valid exp_pc         exp_iaddr
        vecs[0]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 32'h0000_0004};
        vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 32'h0000_0008};
        vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 32'h0000_0008};
        vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 32'h0000_0008};
        vecs[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 32'h0000_0008};
        vecs[5]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 32'h0000_000C};
        vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0008, 32'h0000_0010};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_000C, 32'h0000_0014};
        vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_000C, 32'h0000_0014};
        vecs[9]  = '{1'b1, 32'h0000_0102, 1'b0, 1'b0, 32'h0,         32'h0000_0100};
        vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0100, 32'h0000_0104};
        vecs[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0104, 32'h0000_0108};
        vecs[12] = '{1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0,         32'h0000_0200};
        vecs[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0200, 32'h0000_0204};
        vecs[14] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0204, 32'h0000_0208};
        vecs[15] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,         32'hFFFF_FFFC};
        vecs[16] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[17] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 32'h0000_0004};
        vecs[18] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 32'h0000_0008};
        vecs[19] = '{1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0,         32'h0000_0300};
        vecs[20] = '{1'b1, 32'h0000_0401, 1'b1, 1'b0, 32'h0,         32'h0000_0400};
        vecs[21] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0400, 32'h0000_0404};

        // Reset state, then release away from the rising edge.
        @(negedge clk);
        check32("rst_valid", {31'd0, inst_valid}, 32'd0);
        check32("rst_iaddr", iaddr, RST_PC);
        check32("rst_inst", inst, 32'd0);
        check32("rst_inst_pc", inst_pc, 32'd0);
        rst = 1'b1;

        // Directed table: stall fill, drain, redirects, PC wrap, back-to-back redirects.
        for (int i = 0; i < 22; i++) begin
            step(vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            check32($sformatf("vec%0d_valid", i), {31'd0, inst_valid},
                    {31'd0, vecs[i].exp_valid});
            check32($sformatf("vec%0d_iaddr", i), iaddr, vecs[i].exp_iaddr);
            if (vecs[i].exp_valid) begin
                check32($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].exp_pc);
                check32($sformatf("vec%0d_inst", i), inst, memf(vecs[i].exp_pc));
            end
        end

        // Fill the buffer, then reset mid-cycle; restart streams from RESET_PC.
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
        check32("full_before_rst", {31'd0, inst_valid}, 32'd1);
        async_reset("stall_rst");
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'd0, 1'b1);
            check32($sformatf("restart%0d_pc", i), inst_pc, 32'(i * 4));
        end

        // Reset right after a redirect has started refilling.
        step(1'b1, 32'h0000_0500, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        async_reset("redir_rst");
        step(1'b0, 32'd0, 1'b1);
        check32("post_redir_rst_pc", inst_pc, RST_PC);

        // Random traffic against the reference.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 9) == 0, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Parameter: BUF_DEPTH, 2, instruction buffer entries; fixed at 2 for this revision.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: iaddr  output  32  fetch address to instruction memory; SHALL equal the current PC.
REQ-006 Port: idata  input  32  instruction word returned combinationally by instruction memory for iaddr.
REQ-007 Port: redirect_valid  input  1  branch/jump redirect request, single-cycle pulse or level.
REQ-008 Port: redirect_pc  input  32  redirect target; bits [1:0] ignored and treated as zero.
REQ-009 Port: inst_valid  output  1  buffer head holds a valid instruction.
REQ-010 Port: inst_ready  input  1  decode stage accepts the head this cycle.
REQ-011 Port: inst  output  32  instruction word at buffer head.
REQ-012 Port: inst_pc  output  32  PC of the instruction at buffer head.

Function
REQ-013 State: pc (32b), 2-entry circular buffer of {pc, word}, write pointer, read pointer, 2-bit occupancy count.
REQ-014 Dequeue SHALL occur on a rising edge when inst_valid=1 and inst_ready=1.
REQ-015 Enqueue SHALL occur on a rising edge when redirect_valid=0 and (count<2 or a dequeue occurs that edge); entry = {pc, idata}; pc SHALL advance by 4.
REQ-016 Simultaneous enqueue and dequeue with count=2 SHALL keep count=2 with no data loss or duplication.
REQ-017 When count=2 and no dequeue, pc SHALL hold and no enqueue SHALL occur (stall).
REQ-018 inst_valid SHALL be 1 exactly when count>0; inst/inst_pc SHALL be driven from the read-pointer entry with no combinational path from inst_ready.
REQ-019 inst and inst_pc SHALL hold stable while inst_valid=1 and inst_ready=0.
REQ-020 redirect_valid=1 at a rising edge SHALL: clear count to 0, reset both pointers, load pc with {redirect_pc[31:2],2'b00}, and suppress enqueue; any same-edge dequeue is still accepted by decode.
REQ-021 On the edge after a redirect, inst_valid SHALL be 0; the first post-redirect instruction SHALL appear at inst_valid one cycle after the redirect edge, with latency 1 from fetch to inst_valid in general.
REQ-022 pc addition SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0), with no flag.
REQ-023 Pointers SHALL wrap modulo BUF_DEPTH.
REQ-024 Consecutive redirects SHALL each take effect; the last one before the first enqueue wins.

Reset
REQ-025 rst=0 SHALL immediately, independent of clk, set pc=RESET_PC, count=0, pointers=0, inst_valid=0.
REQ-026 While rst=0, iaddr SHALL equal RESET_PC; inst and inst_pc SHALL read 0.
REQ-027 After rst deasserts, the first enqueue SHALL occur on the first rising edge, with entry {RESET_PC, idata}.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard all buffered instructions.

Verification
REQ-029 Reset, then inst_ready=1 constantly, memory word = address -> inst_pc/inst sequence 0,4,8,... one per cycle starting 1 cycle after reset release.
REQ-030 inst_ready=0 for 5 cycles after reset -> inst_valid=1, count saturates at 2, iaddr holds at 8, inst_pc holds at 0; on inst_ready=1, inst_pc continues 0,4,8,12 with no gaps or repeats.
REQ-031 Redirect to 32'h0000_0102 while buffer full -> next edge inst_valid=0; following edge inst_pc=32'h0000_0100, then 32'h0000_0104.
REQ-032 Redirect asserted on the same edge as a dequeue -> old head consumed once; no old-stream instruction appears afterward.
REQ-033 redirect_pc=32'hFFFF_FFFC, inst_ready=1 -> inst_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
REQ-034 rst pulsed low between clock edges while count=2 -> inst_valid drops to 0 immediately, iaddr=RESET_PC, restart matches REQ-029.
